// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and port numbering for the unified RAM arbiter
package arb_pkg;

   localparam int ARB_NREQ = 3;

   typedef logic [$clog2(ARB_NREQ)-1:0] port_idx_t;

   localparam port_idx_t PORT_CPU  = port_idx_t'(0);
   localparam port_idx_t PORT_BOOT = port_idx_t'(1);
   localparam port_idx_t PORT_DBG  = port_idx_t'(2);

   // Spare index value that no real port uses; marks "nobody holds the lock".
   localparam port_idx_t NO_OWNER  = '1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - cyclic first-one finder starting at a given index
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          valid,
   output logic [IW-1:0] idx
);

   function automatic int wrap(input int v);
      return (v >= N) ? v - N : v;
   endfunction

   // Scan from the far end backwards so the position nearest start wins last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[wrap(int'(start) + k)]) begin
            valid = 1'b1;
            idx   = IW'(wrap(int'(start) + k));
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares the single-port unified RAM between NREQ requesters
module ram_port_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ         = 3,
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      ram_addr,
   output logic [DW-1:0]      ram_din,
   output logic               ram_write,
   input  logic [DW-1:0]      ram_dout
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam int IW = $bits(port_idx_t);

   port_idx_t       owner;
   port_idx_t       rr_ptr;
   logic [CW-1:0]   cnt [1:NREQ-1];

   logic            owner_valid;
   logic            rr_valid;
   port_idx_t       rr_idx;
   logic            starve_any;
   port_idx_t       starve_idx;
   logic            g_any;
   logic            locked_grant;
   port_idx_t       g_idx;
   logic            act;
   logic [NREQ-1:0] rr_req;

   assign owner_valid = (owner != NO_OWNER);
   assign rr_req      = {req[NREQ-1:1], 1'b0};

   rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
      .req   (rr_req),
      .start (rr_ptr),
      .valid (rr_valid),
      .idx   (rr_idx)
   );

   // Lowest-index starved port; only a port still requesting can be forced in.
   always_comb begin
      starve_any = 1'b0;
      starve_idx = '0;
      for (int i = NREQ - 1; i >= 1; i--) begin
         if (req[i] && cnt[i] == CW'(STARVE_LIMIT)) begin
            starve_any = 1'b1;
            starve_idx = port_idx_t'(i);
         end
      end
   end

   always_comb begin
      g_any        = 1'b0;
      locked_grant = 1'b0;
      g_idx        = '0;
      if (owner_valid && req[owner]) begin
         g_any        = 1'b1;
         locked_grant = 1'b1;
         g_idx        = owner;
      end else if (starve_any) begin
         g_any = 1'b1;
         g_idx = starve_idx;
      end else if (req[PORT_CPU]) begin
         g_any = 1'b1;
         g_idx = PORT_CPU;
      end else if (rr_valid) begin
         g_any = 1'b1;
         g_idx = rr_idx;
      end
   end

   // Reset masks the combinational outputs so nothing reaches the RAM while rst_n is low.
   assign act = g_any & rst_n;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = act && (g_idx == port_idx_t'(i));
      end
   end

   assign ram_addr  = act ? addr[g_idx*AW +: AW]  : '0;
   assign ram_din   = act ? wdata[g_idx*DW +: DW] : '0;
   assign ram_write = act & we[g_idx] & req[g_idx];
   assign rdata     = ram_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner  <= NO_OWNER;
         rr_ptr <= port_idx_t'(1);
         rvalid <= '0;
         for (int i = 1; i < NREQ; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         rvalid <= req & gnt & ~we;

         if (owner_valid && !req[owner]) begin
            owner <= NO_OWNER;
         end
         if (act) begin
            if (lock[g_idx]) begin
               owner <= g_idx;
            end else if (g_idx == owner) begin
               owner <= NO_OWNER;
            end
            if (!locked_grant && g_idx != PORT_CPU) begin
               rr_ptr <= (int'(g_idx) == NREQ - 1) ? port_idx_t'(1) : g_idx + port_idx_t'(1);
            end
         end

         for (int i = 1; i < NREQ; i++) begin
            if (req[i] && !gnt[i]) begin
               if (cnt[i] != CW'(STARVE_LIMIT)) begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [2:0]  lock;
   logic [47:0] addr;
   logic [47:0] wdata;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [15:0] rdata;
   logic [15:0] ram_addr;
   logic [15:0] ram_din;
   logic        ram_write;
   logic [15:0] ram_dout;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [256];
   logic        mem_ready = 1'b0;

   logic [2:0]  exp_all [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100,
                                 3'b001, 3'b001, 3'b001, 3'b010, 3'b100};

   ram_port_arbiter #(
      .NREQ(3), .AW(16), .DW(16), .STARVE_LIMIT(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .lock      (lock),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_write (ram_write),
      .ram_dout  (ram_dout)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM macro; preloaded with A000+index on the first edge.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
         mem_ready <= 1'b1;
         ram_dout  <= 16'hA000 | {8'h00, ram_addr[7:0]};
      end else begin
         if (ram_write) mem[ram_addr[7:0]] <= ram_din;
         ram_dout <= mem[ram_addr[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_port(input int p, input logic [15:0] a, input logic [15:0] d);
      addr[p*16 +: 16]  = a;
      wdata[p*16 +: 16] = d;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 3'b111;
      we    = 3'b000;
      lock  = 3'b000;
      addr  = '0;
      wdata = '0;
      set_port(0, 16'h0001, 16'h0);
      set_port(1, 16'h0011, 16'h0);
      set_port(2, 16'h0012, 16'h0);

      // 1: reset with everyone requesting
      step(); step(); #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_write", 32'(ram_write), 32'h0);
      chk("rst_addr", 32'(ram_addr), 32'h0);
      chk("rst_din", 32'(ram_din), 32'h0);
      step(); rst_n = 1'b1; #1;
      chk("post_rst_gnt", 32'(gnt), 32'h1);

      // 2: ports 1 and 2 alternate; rvalid/rdata trail each grant by one cycle
      step(); req = 3'b110; #1;
      chk("rr_gnt_a", 32'(gnt), 32'h2);
      chk("rr_addr_a", 32'(ram_addr), 32'h0011);
      chk("rr_rvalid_a", 32'(rvalid), 32'h1);
      chk("rr_rdata_a", 32'(rdata), 32'hA001);
      step(); #1;
      chk("rr_gnt_b", 32'(gnt), 32'h4);
      chk("rr_rvalid_b", 32'(rvalid), 32'h2);
      chk("rr_rdata_b", 32'(rdata), 32'hA011);
      step(); #1;
      chk("rr_gnt_c", 32'(gnt), 32'h2);
      chk("rr_rvalid_c", 32'(rvalid), 32'h4);
      chk("rr_rdata_c", 32'(rdata), 32'hA012);
      step(); #1;
      chk("rr_gnt_d", 32'(gnt), 32'h4);
      step(); req = 3'b000; #1;
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("rr_rvalid_e", 32'(rvalid), 32'h4);
      step(); #1;
      chk("idle_rvalid", 32'(rvalid), 32'h0);

      // 3: all request; starved ports break through port 0's priority
      req = 3'b111;
      for (int c = 0; c < 11; c++) begin
         #1;
         chk($sformatf("starve_gnt_%0d", c), 32'(gnt), 32'(exp_all[c]));
         step();
      end
      req = 3'b000;
      step();

      // 4: port 1 locked write burst against a requesting port 0
      req  = 3'b010;
      we   = 3'b010;
      lock = 3'b010;
      for (int b = 0; b < 8; b++) begin
         set_port(1, 16'h0010, 16'h1000 + 16'(b));
         if (b == 1) req = 3'b011;
         if (b == 7) lock = 3'b000;
         #1;
         chk($sformatf("lock_gnt_%0d", b), 32'(gnt), 32'h2);
         chk($sformatf("lock_write_%0d", b), 32'(ram_write), 32'h1);
         chk($sformatf("lock_din_%0d", b), 32'(ram_din), 32'(16'h1000 + 16'(b)));
         step();
      end
      req = 3'b001;
      we  = 3'b000;
      #1;
      chk("unlock_gnt", 32'(gnt), 32'h1);
      step(); req = 3'b000; #1;
      chk("unlock_rvalid", 32'(rvalid), 32'h1);
      chk("unlock_rdata", 32'(rdata), 32'hA001);

      // 5: write then read-back of the same address in consecutive cycles
      step();
      req = 3'b100;
      we  = 3'b100;
      set_port(2, 16'h0020, 16'hBEEF);
      #1;
      chk("raw_wr_gnt", 32'(gnt), 32'h4);
      chk("raw_wr_write", 32'(ram_write), 32'h1);
      chk("raw_wr_din", 32'(ram_din), 32'hBEEF);
      step(); we = 3'b000; #1;
      chk("raw_rd_gnt", 32'(gnt), 32'h4);
      chk("raw_rd_write", 32'(ram_write), 32'h0);
      chk("raw_rd_addr", 32'(ram_addr), 32'h0020);
      chk("raw_wr_no_rvalid", 32'(rvalid), 32'h0);
      step(); req = 3'b000; #1;
      chk("raw_rvalid", 32'(rvalid), 32'h4);
      chk("raw_rdata", 32'(rdata), 32'hBEEF);

      // 6: reset lands mid-lock while a read result is pending
      step();
      req  = 3'b010;
      we   = 3'b010;
      lock = 3'b010;
      set_port(1, 16'h0030, 16'h2222);
      #1;
      chk("ml_wr_gnt", 32'(gnt), 32'h2);
      step(); req = 3'b011; we = 3'b000; #1;
      chk("ml_rd_gnt", 32'(gnt), 32'h2);
      step(); we = 3'b010; #1;
      chk("ml_pre_rvalid", 32'(rvalid), 32'h2);
      chk("ml_pre_rdata", 32'(rdata), 32'h2222);
      chk("ml_pre_write", 32'(ram_write), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("ml_rst_gnt", 32'(gnt), 32'h0);
      chk("ml_rst_rvalid", 32'(rvalid), 32'h0);
      chk("ml_rst_write", 32'(ram_write), 32'h0);
      step(); rst_n = 1'b1; #1;
      chk("ml_post_gnt", 32'(gnt), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
